// File: rtl/sram_rd_pkg.sv
// Shared types and default sizing for the sram burst read engine.
package sram_rd_pkg;

   localparam int P_AWIDTH    = 32;
   localparam int P_DWIDTH    = 32;
   localparam int P_DEPTH     = 4096;
   localparam int P_LWIDTH    = 16;
   localparam int P_BUF_DEPTH = 4;
   localparam int BUF_AW      = $clog2(P_BUF_DEPTH);

   // Controller states; exported on o_state for observation.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Return buffer entry: end-of-burst tag above the data word.
   typedef struct packed {
      logic                last;
      logic [P_DWIDTH-1:0] data;
   } buf_entry_t;

endpackage

// File: rtl/sram_rd_buf.sv
// Small first-word-fall-through FIFO holding returned sram words plus
// their end-of-burst tag. The head entry is visible whenever non-empty.
module sram_rd_buf
   import sram_rd_pkg::*;
#(
   parameter int WIDTH = $bits(buf_entry_t),
   parameter int DEPTH = P_BUF_DEPTH,
   parameter int AW    = BUF_AW
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_push_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_empty
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;

   // A pop on an empty buffer is meaningless and is dropped.
   assign w_do_pop = i_pop && (r_count != '0);

   // Storage, pointers and occupancy; pointers wrap at DEPTH-1 so any depth works.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({i_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/sram_rd_ctrl.sv
// Burst read engine on the sram read port: issues reads for a command,
// absorbs the one-cycle sram latency and returns words as a valid/ready
// stream with a last tag, then pulses done.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge; a source holding valid keeps its payload stable
// until that transfer, and ready may change freely.
module sram_rd_ctrl
   import sram_rd_pkg::*;
#(
   parameter int AWIDTH    = P_AWIDTH,
   parameter int DWIDTH    = P_DWIDTH,
   parameter int DEPTH     = P_DEPTH,
   parameter int LWIDTH    = P_LWIDTH,
   parameter int BUF_DEPTH = P_BUF_DEPTH
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [AWIDTH-1:0] i_cmd_addr,
   input  logic [LWIDTH-1:0] i_cmd_len,
   output logic              o_read_en,
   output logic [AWIDTH-1:0] o_read_addr,
   input  logic [DWIDTH-1:0] i_read_data,
   output logic              o_dout_valid,
   input  logic              i_dout_ready,
   output logic [DWIDTH-1:0] o_dout_data,
   output logic              o_dout_last,
   output logic              o_done,
   output state_t            o_state
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AWIDTH-1:0] r_addr;
   logic [LWIDTH-1:0] r_remaining;
   logic              r_inflight;
   logic              r_inflight_last;
   logic              w_accept;
   logic              w_issue;
   logic              w_last_issue;
   logic              w_pop;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [CW:0]       w_occupancy;
   logic [DWIDTH:0]   w_head;

   // Occupancy counts the word still in flight from the sram; same-cycle pops
   // are deliberately ignored so a push can never find the buffer full.
   assign w_occupancy  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign w_accept     = i_cmd_valid && (r_state == IDLE);
   assign w_issue      = (r_state == READ) && (r_remaining != '0) &&
                         (w_occupancy < (CW + 1)'(BUF_DEPTH));
   assign w_last_issue = w_issue && (r_remaining == LWIDTH'(1));
   assign w_pop        = !w_empty && i_dout_ready;

   // Address and remaining-length counters; address wraps to 0 past DEPTH-1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr      <= '0;
         r_remaining <= '0;
      end else if (w_accept) begin
         r_addr      <= i_cmd_addr;
         r_remaining <= i_cmd_len;
      end else if (w_issue) begin
         r_addr      <= (r_addr == AWIDTH'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
         r_remaining <= r_remaining - 1'b1;
      end
   end

   // Track the read whose data arrives next cycle, and whether it ends the burst.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_last_issue;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode plus the state-derived handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      o_cmd_ready = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) w_state_nxt = (i_cmd_len != '0) ? READ : DONE;
         end
         READ: begin
            if (w_last_issue) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_pop && w_head[DWIDTH]) w_state_nxt = DONE;
         end
         DONE: begin
            o_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   sram_rd_buf #(
      .WIDTH (DWIDTH + 1),
      .DEPTH (BUF_DEPTH),
      .AW    ($clog2(BUF_DEPTH))
   ) u_buf (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (r_inflight),
      .i_push_data ({r_inflight_last, i_read_data}),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_empty     (w_empty)
   );

   assign o_read_en    = w_issue;
   assign o_read_addr  = r_addr;
   assign o_dout_valid = !w_empty;
   assign o_dout_data  = w_head[DWIDTH-1:0];
   assign o_dout_last  = w_head[DWIDTH];
   assign o_state      = r_state;

   // Start addresses at or beyond the sram size are a master error.
   a_cmd_addr_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      w_accept |-> ({1'b0, i_cmd_addr} < (AWIDTH + 1)'(DEPTH)));

endmodule
